mem_arbiter: RTL and testbench

Arbiter and sequencer for a single shared memory port between the instruction-fetch path and the load/store path of the core. It accepts one request at a time from either requester, registers it, and drives it onto the memory port. It waits for the memory response and returns it to the requester that owns the transaction. Data accesses have priority, and a burst limiter guarantees fetch progress.

---
 rtl/mem_arbiter_if.sv | 49 ++++
 rtl/mem_arbiter.sv | 103 ++++++++++
 tb/tb_mem_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory port bundle for mem_arbiter
interface mem_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 16
);
  logic                       if_req_valid;
  logic [ADDRESS_WIDTH-1:0]   if_addr;
  logic                       if_req_ready;
  logic                       if_rsp_valid;
  logic [DATA_WIDTH-1:0]      if_rdata;

  logic                       d_req_valid;
  logic                       d_we;
  logic [ADDRESS_WIDTH-1:0]   d_addr;
  logic [DATA_WIDTH-1:0]      d_wdata;
  logic [DATA_WIDTH/8-1:0]    d_be;
  logic                       d_req_ready;
  logic                       d_rsp_valid;
  logic [DATA_WIDTH-1:0]      d_rdata;

  logic                       mem_req_valid;
  logic                       mem_we;
  logic [ADDRESS_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]      mem_wdata;
  logic [DATA_WIDTH/8-1:0]    mem_be;
  logic                       mem_req_ready;
  logic                       mem_rsp_valid;
  logic [DATA_WIDTH-1:0]      mem_rdata;

  // Arbiter side
  modport slave (
    input  if_req_valid, if_addr,
    output if_req_ready, if_rsp_valid, if_rdata,
    input  d_req_valid, d_we, d_addr, d_wdata, d_be,
    output d_req_ready, d_rsp_valid, d_rdata,
    output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  // Requesters and memory side
  modport master (
    output if_req_valid, if_addr,
    input  if_req_ready, if_rsp_valid, if_rdata,
    output d_req_valid, d_we, d_addr, d_wdata, d_be,
    input  d_req_ready, d_rsp_valid, d_rdata,
    input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/load-store arbiter and sequencer for one memory port
module mem_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 16,
  parameter int BURST_LIMIT   = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int CNT_WIDTH = $clog2(BURST_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                   state, state_next;
  logic [CNT_WIDTH-1:0]     burst_cnt;
  logic                     owner_data;
  logic                     fetch_priority;
  logic                     d_grant, if_grant;

  logic                     mem_we_r;
  logic [ADDRESS_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0]    mem_wdata_r;
  logic [BE_WIDTH-1:0]      mem_be_r;
  logic                     if_rsp_valid_r, d_rsp_valid_r;
  logic [DATA_WIDTH-1:0]    if_rdata_r, d_rdata_r;

  // Fetch only overrides data once data has had BURST_LIMIT consecutive wins
  assign fetch_priority   = (burst_cnt == CNT_WIDTH'(BURST_LIMIT));
  assign bus.if_req_ready = rst && (state == IDLE) && (!bus.d_req_valid || fetch_priority);
  assign bus.d_req_ready  = rst && (state == IDLE) && (!bus.if_req_valid || !fetch_priority);
  assign d_grant          = bus.d_req_valid && bus.d_req_ready;
  assign if_grant         = bus.if_req_valid && bus.if_req_ready;

  assign bus.mem_req_valid = (state == REQ);
  assign bus.mem_we        = mem_we_r;
  assign bus.mem_addr      = mem_addr_r;
  assign bus.mem_wdata     = mem_wdata_r;
  assign bus.mem_be        = mem_be_r;
  assign bus.if_rsp_valid  = if_rsp_valid_r;
  assign bus.d_rsp_valid   = d_rsp_valid_r;
  assign bus.if_rdata      = if_rdata_r;
  assign bus.d_rdata       = d_rdata_r;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (d_grant || if_grant) state_next = REQ;
      REQ:     if (bus.mem_req_ready) state_next = WAIT;
      WAIT:    if (bus.mem_rsp_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      burst_cnt      <= '0;
      owner_data     <= 1'b0;
      mem_we_r       <= 1'b0;
      mem_addr_r     <= '0;
      mem_wdata_r    <= '0;
      mem_be_r       <= '0;
      if_rsp_valid_r <= 1'b0;
      d_rsp_valid_r  <= 1'b0;
      if_rdata_r     <= '0;
      d_rdata_r      <= '0;
    end else begin
      state          <= state_next;
      if_rsp_valid_r <= 1'b0;
      d_rsp_valid_r  <= 1'b0;
      if (d_grant) begin
        mem_we_r    <= bus.d_we;
        mem_addr_r  <= bus.d_addr;
        mem_wdata_r <= bus.d_wdata;
        mem_be_r    <= bus.d_be;
        owner_data  <= 1'b1;
        if (!bus.if_req_valid)
          burst_cnt <= '0;
        else if (!fetch_priority)
          burst_cnt <= burst_cnt + CNT_WIDTH'(1);
      end else if (if_grant) begin
        mem_we_r    <= 1'b0;
        mem_addr_r  <= bus.if_addr;
        mem_wdata_r <= '0;
        mem_be_r    <= '1;
        owner_data  <= 1'b0;
        burst_cnt   <= '0;
      end
      // Responses outside WAIT are stray and dropped
      if (state == WAIT && bus.mem_rsp_valid) begin
        if (owner_data) begin
          d_rdata_r     <= bus.mem_rdata;
          d_rsp_valid_r <= 1'b1;
        end else begin
          if_rdata_r     <= bus.mem_rdata;
          if_rsp_valid_r <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int BL = 4;
  localparam int NCYC = 4000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  mem_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .BURST_LIMIT(BL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: one outstanding transaction, count of consecutive data wins
  bit            busy, accepted, own_data;
  int            consec;
  logic          e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic [3:0]    e_be;
  bit            wdata_known;
  bit            e_if_rsp, e_d_rsp;
  logic [DW-1:0] e_if_rdata, e_d_rdata;
  bit            d_pend, i_pend;
  bit            er_d, er_i, pf;
  int            d_wins, i_wins;

  task automatic model_reset();
    busy = 0; accepted = 0; consec = 0; own_data = 0;
    e_we = 0; e_addr = '0; e_wdata = '0; e_be = '0; wdata_known = 1;
    e_if_rdata = '0; e_d_rdata = '0;
  endtask

  initial begin
    rst = 1'b0;
    bus.if_req_valid = 0; bus.if_addr = '0;
    bus.d_req_valid = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
    bus.mem_req_ready = 0; bus.mem_rsp_valid = 0; bus.mem_rdata = '0;
    d_pend = 0; i_pend = 0; d_wins = 0; i_wins = 0;
    e_if_rsp = 0; e_d_rsp = 0;
    model_reset();
    repeat (2) @(posedge clk);

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      check("mem_req_valid", 64'(bus.mem_req_valid), 64'(busy && !accepted));
      check("mem_we", 64'(bus.mem_we), 64'(e_we));
      check("mem_addr", 64'(bus.mem_addr), 64'(e_addr));
      check("mem_be", 64'(bus.mem_be), 64'(e_be));
      if (wdata_known) check("mem_wdata", 64'(bus.mem_wdata), 64'(e_wdata));
      check("if_rsp_valid", 64'(bus.if_rsp_valid), 64'(e_if_rsp));
      check("d_rsp_valid", 64'(bus.d_rsp_valid), 64'(e_d_rsp));
      check("if_rdata", 64'(bus.if_rdata), 64'(e_if_rdata));
      check("d_rdata", 64'(bus.d_rdata), 64'(e_d_rdata));

      rst = (c < 2) ? 1'b0 : ($urandom_range(0, 79) != 0);
      if (!d_pend && $urandom_range(0, 3) != 0) begin
        d_pend = 1;
        bus.d_we = 1'($urandom);
        bus.d_addr = AW'($urandom);
        bus.d_wdata = $urandom;
        bus.d_be = 4'($urandom);
      end else if (d_pend && $urandom_range(0, 29) == 0) d_pend = 0;
      if (!i_pend && $urandom_range(0, 3) != 0) begin
        i_pend = 1;
        bus.if_addr = AW'($urandom);
      end else if (i_pend && $urandom_range(0, 29) == 0) i_pend = 0;
      bus.d_req_valid = d_pend;
      bus.if_req_valid = i_pend;
      bus.mem_req_ready = ($urandom_range(0, 2) != 0);
      bus.mem_rsp_valid = ($urandom_range(0, 1) != 0);
      bus.mem_rdata = $urandom;
      #1;

      pf = (consec == BL);
      er_d = rst && !busy && (!i_pend || !pf);
      er_i = rst && !busy && (!d_pend || pf);
      check("d_req_ready", 64'(bus.d_req_ready), 64'(er_d));
      check("if_req_ready", 64'(bus.if_req_ready), 64'(er_i));

      e_if_rsp = 0; e_d_rsp = 0;
      if (!rst) model_reset();
      else if (!busy) begin
        if (d_pend && er_d) begin
          busy = 1; own_data = 1; d_pend = 0; d_wins++;
          e_we = bus.d_we; e_addr = bus.d_addr; e_wdata = bus.d_wdata; e_be = bus.d_be;
          wdata_known = 1;
          consec = i_pend ? ((consec < BL) ? consec + 1 : BL) : 0;
        end else if (i_pend && er_i) begin
          busy = 1; own_data = 0; i_pend = 0; i_wins++;
          e_we = 0; e_addr = bus.if_addr; e_be = 4'hF; wdata_known = 0;
          consec = 0;
        end
      end else if (!accepted) begin
        if (bus.mem_req_ready) accepted = 1;
      end else if (bus.mem_rsp_valid) begin
        busy = 0; accepted = 0;
        if (own_data) begin e_d_rsp = 1; e_d_rdata = bus.mem_rdata; end
        else begin e_if_rsp = 1; e_if_rdata = bus.mem_rdata; end
      end
    end

    @(negedge clk);
    check("final_if_rsp_valid", 64'(bus.if_rsp_valid), 64'(e_if_rsp));
    check("final_d_rsp_valid", 64'(bus.d_rsp_valid), 64'(e_d_rsp));
    if (d_wins == 0 || i_wins == 0) begin
      errors++;
      $display("FAIL coverage got d_wins=%0d i_wins=%0d expected both nonzero", d_wins, i_wins);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
